key_pair_debounce: RTL and testbench

Conditions two raw, active-low push-button inputs into clean, active-high logic levels for the two-input gate experiments (A and B operands). Each channel has a two-flop synchronizer and a debounce filter with its own counter. Each channel also produces one-cycle press and release event pulses. The block sits between the board keys and any combinational gate under test, so the gate only sees bounce-free operands.

---
 rtl/key_pair_debounce.sv | 87 ++++++++
 tb/tb_key_pair_debounce.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/key_pair_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_pair_debounce
//  Description : Two independent active-low key conditioners (sync + debounce)
//                giving active-high levels and one-cycle press/release pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_pair_debounce #(
    parameter int CNT_MAX = 999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_a_n,
    input  logic key_b_n,
    output logic gate_a,
    output logic gate_b,
    output logic press_a,
    output logic press_b,
    output logic rel_a,
    output logic rel_b
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(CNT_MAX);

    logic [1:0] w_key_n;
    logic [1:0] w_lvl;
    logic [1:0] w_press;
    logic [1:0] w_rel;

    assign w_key_n = {key_b_n, key_a_n};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_chan
            logic             r_sync1;
            logic             r_sync2;
            logic             r_lvl;
            logic             r_press;
            logic             r_rel;
            logic [CNT_W-1:0] r_cnt;
            logic             w_key_sync;
            logic             w_accept;

            assign w_key_sync = ~r_sync2;
            // A new level is taken only after CNT_MAX+1 consecutive mismatches.
            assign w_accept   = (w_key_sync != r_lvl) && (r_cnt == c_CNT_MAX);

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_lvl   <= 1'b0;
                    r_press <= 1'b0;
                    r_rel   <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_key_n[g];
                    r_sync2 <= r_sync1;
                    r_press <= w_accept &  w_key_sync;
                    r_rel   <= w_accept & ~w_key_sync;
                    if (w_key_sync == r_lvl) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        r_lvl <= w_key_sync;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_lvl[g]   = r_lvl;
            assign w_press[g] = r_press;
            assign w_rel[g]   = r_rel;
        end
    endgenerate

    assign gate_a  = w_lvl[0];
    assign gate_b  = w_lvl[1];
    assign press_a = w_press[0];
    assign press_b = w_press[1];
    assign rel_a   = w_rel[0];
    assign rel_b   = w_rel[1];

endmodule
`default_nettype wire

// File: tb/tb_key_pair_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_pair_debounce
//  Description : Self-checking vector bench for key_pair_debounce at CNT_MAX=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_pair_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_a_n = 1'b0;
    logic key_b_n = 1'b0;
    logic gate_a, gate_b, press_a, press_b, rel_a, rel_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ka;
        logic       kb;
        logic       rs;
        logic [5:0] exp;   // {gate_a, gate_b, press_a, press_b, rel_a, rel_b}
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    key_pair_debounce #(.CNT_MAX(4)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .key_a_n (key_a_n),
        .key_b_n (key_b_n),
        .gate_a  (gate_a),
        .gate_b  (gate_b),
        .press_a (press_a),
        .press_b (press_b),
        .rel_a   (rel_a),
        .rel_b   (rel_b)
    );

    function automatic logic [5:0] outs();
        return {gate_a, gate_b, press_a, press_b, rel_a, rel_b};
    endfunction

    task automatic add(input int n, input logic ka, input logic kb,
                       input logic rs, input logic [5:0] e);
        repeat (n) vecs.push_back('{ka: ka, kb: kb, rs: rs, exp: e});
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic ka, input logic kb, input logic rs);
        @(negedge clk);
        key_a_n = ka;
        key_b_n = kb;
        rst     = rs;
        @(posedge clk);
        #1;
    endtask

    int lat;
    logic seen;

    initial begin
        // Reset with both keys held, then both held through release.
        add(3, 0, 0, 1, 6'b000000);
        add(6, 0, 0, 0, 6'b000000);
        add(1, 0, 0, 0, 6'b111100);
        add(1, 0, 0, 0, 6'b110000);
        add(6, 1, 1, 0, 6'b110000);
        add(1, 1, 1, 0, 6'b000011);
        add(1, 1, 1, 0, 6'b000000);
        // Clean press of A held 20 cycles, then release.
        add(6, 0, 1, 0, 6'b000000);
        add(1, 0, 1, 0, 6'b101000);
        add(13, 0, 1, 0, 6'b100000);
        add(6, 1, 1, 0, 6'b100000);
        add(1, 1, 1, 0, 6'b000010);
        add(2, 1, 1, 0, 6'b000000);
        // Bounce on B: 0,1,0,0,1,0 then held low.
        add(1, 1, 0, 0, 6'b000000);
        add(1, 1, 1, 0, 6'b000000);
        add(2, 1, 0, 0, 6'b000000);
        add(1, 1, 1, 0, 6'b000000);
        add(1, 1, 0, 0, 6'b000000);
        add(5, 1, 0, 0, 6'b000000);
        add(1, 1, 0, 0, 6'b010100);
        add(1, 1, 0, 0, 6'b010000);
        add(6, 1, 1, 0, 6'b010000);
        add(1, 1, 1, 0, 6'b000001);
        add(1, 1, 1, 0, 6'b000000);
        // Four-cycle glitch on A is swallowed.
        add(4, 0, 1, 0, 6'b000000);
        add(6, 1, 1, 0, 6'b000000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ka, vecs[i].kb, vecs[i].rs);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Reset mid-count while A stays held.
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        check("midrst_pre", outs(), 6'b000000);
        step(0, 1, 1);
        check("midrst_in_reset", outs(), 6'b000000);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            step(0, 1, 0);
            lat++;
            if (gate_a) seen = 1'b1;
        end
        check("midrst_latency", 6'(lat), 6'd7);
        check("midrst_rise", outs(), 6'b101000);
        step(0, 1, 0);
        check("midrst_pulse_end", outs(), 6'b100000);

        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            step(1, 1, 0);
            lat++;
            if (!gate_a) seen = 1'b1;
        end
        check("release_latency", 6'(lat), 6'd7);
        check("release_fall", outs(), 6'b000010);
        step(1, 1, 0);
        check("idle_final", outs(), 6'b000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
